// File: rtl/crypto_core16.sv
// 16-bit, 4-round mini-AES block cipher: one block per command, four steps per round.
// Encrypt returns ciphertext and K4; decrypt from K4 recovers plaintext and K0.
module crypto_core16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] key_inbus,
    input  logic [15:0] data_inbus,
    input  logic [1:0]  cript_or_decript_signal,
    input  logic        bgn,
    output logic        fin,
    output logic [15:0] key_outbus,
    output logic [15:0] data_outbus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_STEP1, S_STEP2, S_STEP3, S_STEP4, S_DONE
    } state_t;

    state_t      r_st;
    logic [2:0]  r_rnd;
    logic        r_dec;
    logic [15:0] r_din;
    logic [15:0] r_kin;
    logic [15:0] r_s;
    logic [15:0] r_k;

    logic [15:0] w_s_sub;
    logic [15:0] w_k_sub;
    logic [15:0] w_s_shf;
    logic [15:0] w_s_mix;
    logic        w_last;
    logic        w_go;

    function automatic logic [7:0] gf8_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] t;
        p = 8'h00;
        t = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ t;
            t = {t[6:0], 1'b0} ^ (t[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf8_inv(input logic [7:0] a);
        logic [7:0] t;
        t = a;
        for (int i = 0; i < 6; i++) t = gf8_mul(gf8_mul(t, t), a);
        return gf8_mul(t, t);
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [7:0] t;
        t = x;
        for (int i = 0; i < n; i++) t = {t[6:0], t[7]};
        return t;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b, input logic inv);
        logic [7:0] t;
        logic [7:0] g;
        if (inv) begin
            t = rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05;
            return gf8_inv(t);
        end
        g = gf8_inv(b);
        return g ^ rotl8(g, 1) ^ rotl8(g, 2) ^ rotl8(g, 3) ^ rotl8(g, 4) ^ 8'h63;
    endfunction

    function automatic logic [3:0] xt4(input logic [3:0] n);
        return {n[2:0], 1'b0} ^ (n[3] ? 4'h3 : 4'h0);
    endfunction

    // Matrix [3 2; 2 3] over GF(2^4) is its own inverse
    function automatic logic [7:0] mix8(input logic [7:0] b);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = xt4(b[7:4]) ^ b[7:4] ^ xt4(b[3:0]);
        lo = xt4(b[7:4]) ^ xt4(b[3:0]) ^ b[3:0];
        return {hi, lo};
    endfunction

    assign w_s_sub = {sbox(r_s[15:8], r_dec), sbox(r_s[7:0], r_dec)};
    assign w_k_sub = {sbox(r_k[15:8], r_dec), sbox(r_k[7:0], r_dec)};
    assign w_s_shf = {r_s[15:12], r_s[3:0], r_s[7:4], r_s[11:8]};
    assign w_s_mix = {mix8(r_s[15:8]), mix8(r_s[7:0])};
    assign w_last  = r_dec ? (r_rnd == 3'd1) : (r_rnd == 3'd4);
    assign w_go    = bgn && (cript_or_decript_signal == 2'b01 ||
                             cript_or_decript_signal == 2'b10);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_st        <= S_IDLE;
            r_rnd       <= 3'd0;
            r_dec       <= 1'b0;
            r_din       <= 16'h0000;
            r_kin       <= 16'h0000;
            r_s         <= 16'h0000;
            r_k         <= 16'h0000;
            fin         <= 1'b0;
            data_outbus <= 16'h0000;
            key_outbus  <= 16'h0000;
        end else begin
            fin <= 1'b0;
            unique case (r_st)
                S_IDLE: begin
                    if (w_go) begin
                        r_dec <= cript_or_decript_signal[1];
                        r_din <= data_inbus;
                        r_kin <= key_inbus;
                        r_st  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_s   <= r_din ^ r_kin;
                    r_k   <= r_kin;
                    r_rnd <= r_dec ? 3'd4 : 3'd1;
                    r_st  <= S_STEP1;
                end
                S_STEP1: begin
                    if (r_dec) begin
                        r_s <= w_s_shf;
                    end else begin
                        r_s <= w_s_sub;
                        r_k <= w_k_sub;
                    end
                    r_st <= S_STEP2;
                end
                S_STEP2: begin
                    if (r_dec) begin
                        r_s <= w_s_sub;
                        r_k <= w_k_sub;
                    end else begin
                        r_s <= w_s_shf;
                    end
                    r_st <= S_STEP3;
                end
                S_STEP3: begin
                    if (r_dec) r_s <= r_s ^ r_k;
                    else if (r_rnd != 3'd4) r_s <= w_s_mix;
                    r_st <= S_STEP4;
                end
                S_STEP4: begin
                    if (r_dec) begin
                        if (r_rnd != 3'd1) r_s <= w_s_mix;
                    end else begin
                        r_s <= r_s ^ r_k;
                    end
                    if (w_last) begin
                        r_st <= S_DONE;
                    end else begin
                        r_rnd <= r_dec ? r_rnd - 3'd1 : r_rnd + 3'd1;
                        r_st  <= S_STEP1;
                    end
                end
                S_DONE: begin
                    data_outbus <= r_s;
                    key_outbus  <= r_k;
                    fin         <= 1'b1;
                    r_st        <= S_IDLE;
                end
                default: r_st <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crypto_core16.sv
// Self-checking bench for crypto_core16: directed vectors, random
// round trips against a table-driven model, and control corner cases.
module tb_crypto_core16;

    logic        clk;
    logic        rst;
    logic [15:0] key_inbus;
    logic [15:0] data_inbus;
    logic [1:0]  cript_or_decript_signal;
    logic        bgn;
    logic        fin;
    logic [15:0] key_outbus;
    logic [15:0] data_outbus;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0] sb  [256];
    logic [7:0] isb [256];

    crypto_core16 dut (
        .clk                     (clk),
        .rst                     (rst),
        .key_inbus               (key_inbus),
        .data_inbus              (data_inbus),
        .cript_or_decript_signal (cript_or_decript_signal),
        .bgn                     (bgn),
        .fin                     (fin),
        .key_outbus              (key_outbus),
        .data_outbus             (data_outbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rl(input logic [7:0] x, input int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    // S-box table from the classic generator walk over GF(2^8)
    task automatic build_sbox();
        logic [7:0] p;
        logic [7:0] q;
        logic [7:0] x;
        p = 8'h01;
        q = 8'h01;
        for (int i = 0; i < 255; i++) begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b00};
            q = q ^ {q[3:0], 4'h0};
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sb[p] = x ^ 8'h63;
        end
        sb[0] = 8'h63;
        for (int i = 0; i < 256; i++) isb[sb[i]] = 8'(i);
    endtask

    function automatic logic [3:0] g4(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [3:0] t;
        r = 4'h0;
        t = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ t;
            t = t[3] ? ({t[2:0], 1'b0} ^ 4'h3) : {t[2:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [15:0] m_sub(input logic [15:0] v);
        return {sb[v[15:8]], sb[v[7:0]]};
    endfunction

    function automatic logic [15:0] m_isub(input logic [15:0] v);
        return {isb[v[15:8]], isb[v[7:0]]};
    endfunction

    function automatic logic [15:0] m_shift(input logic [15:0] v);
        logic [7:0] h;
        logic [7:0] l;
        h = v[15:8];
        l = v[7:0];
        return {h[7:4], l[3:0], l[7:4], h[3:0]};
    endfunction

    function automatic logic [15:0] m_mix(input logic [15:0] v);
        logic [15:0] r;
        for (int b = 0; b < 2; b++) begin
            logic [3:0] nh;
            logic [3:0] nl;
            nh = v[8*b+4 +: 4];
            nl = v[8*b +: 4];
            r[8*b+4 +: 4] = g4(4'h3, nh) ^ g4(4'h2, nl);
            r[8*b +: 4]   = g4(4'h2, nh) ^ g4(4'h3, nl);
        end
        return r;
    endfunction

    task automatic m_enc(input logic [15:0] p, input logic [15:0] k0, input int nr,
                         output logic [15:0] s, output logic [15:0] k);
        s = p ^ k0;
        k = k0;
        for (int r = 1; r <= nr; r++) begin
            k = m_sub(k);
            s = m_shift(m_sub(s));
            if (r != 4) s = m_mix(s);
            s = s ^ k;
        end
    endtask

    task automatic m_dec(input logic [15:0] c, input logic [15:0] k4,
                         output logic [15:0] s, output logic [15:0] k);
        s = c ^ k4;
        k = k4;
        for (int r = 4; r >= 1; r--) begin
            k = m_isub(k);
            s = m_isub(m_shift(s)) ^ k;
            if (r != 1) s = m_mix(s);
        end
    endtask

    task automatic run_op(input logic [1:0] mode, input logic [15:0] din,
                          input logic [15:0] kin, input bit watch, input bit corrupt,
                          output logic [15:0] dout, output logic [15:0] kout);
        int e;
        bit got;
        logic [15:0] ms;
        logic [15:0] mk;
        cript_or_decript_signal = mode;
        data_inbus = din;
        key_inbus  = kin;
        bgn = 1'b1;
        tick();
        bgn = 1'b0;
        got = 1'b0;
        e = 0;
        while (!got && e < 40) begin
            tick();
            e++;
            if (watch && (e == 5 || e == 9 || e == 13)) begin
                m_enc(din, kin, (e - 1) / 4, ms, mk);
                chk("round_state", 32'(dut.r_s), 32'(ms));
            end
            if (corrupt && e == 5) begin
                cript_or_decript_signal = mode ^ 2'b11;
                data_inbus = 16'($urandom);
                key_inbus  = 16'($urandom);
            end
            if (fin) got = 1'b1;
        end
        chk("latency", 32'(e), 32'd18);
        dout = data_outbus;
        kout = key_outbus;
        tick();
        chk("fin_width", 32'(fin), 32'd0);
    endtask

    initial begin
        logic [15:0] d;
        logic [15:0] k;
        logic [15:0] d2;
        logic [15:0] k2;
        logic [15:0] ed;
        logic [15:0] ek;
        logic [15:0] p;
        logic [15:0] kk;
        logic [15:0] hold;
        int nfin;
        int q[$];

        build_sbox();

        rst = 1'b1;
        bgn = 1'b1;
        cript_or_decript_signal = 2'b01;
        data_inbus = 16'($urandom);
        key_inbus  = 16'($urandom);
        tick();
        data_inbus = 16'($urandom);
        key_inbus  = 16'($urandom);
        tick();
        chk("reset_fin", 32'(fin), 32'd0);
        chk("reset_data", 32'(data_outbus), 32'h0000);
        chk("reset_key", 32'(key_outbus), 32'h0000);
        rst = 1'b0;
        bgn = 1'b0;
        tick();

        run_op(2'b01, 16'h0000, 16'h0000, 1'b1, 1'b0, d, k);
        chk("enc0_data", 32'(d), 32'hBEBE);
        chk("enc0_key", 32'(k), 32'h7676);

        run_op(2'b10, 16'hBEBE, 16'h7676, 1'b0, 1'b0, d, k);
        chk("dec0_data", 32'(d), 32'h0000);
        chk("dec0_key", 32'(k), 32'h0000);

        run_op(2'b01, 16'h59B3, 16'h1325, 1'b0, 1'b0, d, k);
        m_enc(16'h59B3, 16'h1325, 4, ed, ek);
        chk("rt1_enc_data", 32'(d), 32'(ed));
        chk("rt1_enc_key", 32'(k), 32'(ek));
        run_op(2'b10, d, k, 1'b0, 1'b0, d2, k2);
        chk("rt1_dec_data", 32'(d2), 32'h59B3);
        chk("rt1_dec_key", 32'(k2), 32'h1325);

        run_op(2'b01, 16'h36CB, 16'hA058, 1'b0, 1'b0, d, k);
        run_op(2'b10, d, k, 1'b0, 1'b0, d2, k2);
        chk("rt2_dec_data", 32'(d2), 32'h36CB);
        chk("rt2_dec_key", 32'(k2), 32'hA058);

        for (int i = 0; i < 6; i++) begin
            p  = 16'($urandom);
            kk = 16'($urandom);
            run_op(2'b01, p, kk, 1'b0, 1'b0, d, k);
            m_enc(p, kk, 4, ed, ek);
            chk("rnd_enc_data", 32'(d), 32'(ed));
            chk("rnd_enc_key", 32'(k), 32'(ek));
            p  = 16'($urandom);
            kk = 16'($urandom);
            run_op(2'b10, p, kk, 1'b0, 1'b0, d, k);
            m_dec(p, kk, ed, ek);
            chk("rnd_dec_data", 32'(d), 32'(ed));
            chk("rnd_dec_key", 32'(k), 32'(ek));
        end

        hold = data_outbus;
        nfin = 0;
        bgn = 1'b1;
        data_inbus = 16'($urandom);
        cript_or_decript_signal = 2'b00;
        repeat (25) begin
            tick();
            if (fin) nfin++;
        end
        cript_or_decript_signal = 2'b11;
        repeat (25) begin
            tick();
            if (fin) nfin++;
        end
        bgn = 1'b0;
        chk("noop_fin", 32'(nfin), 32'd0);
        chk("noop_hold", 32'(data_outbus), 32'(ed));

        p  = 16'($urandom);
        kk = 16'($urandom);
        run_op(2'b01, p, kk, 1'b0, 1'b1, d, k);
        m_enc(p, kk, 4, ed, ek);
        chk("corrupt_data", 32'(d), 32'(ed));
        chk("corrupt_key", 32'(k), 32'(ek));

        cript_or_decript_signal = 2'b10;
        data_inbus = 16'($urandom);
        key_inbus  = 16'($urandom);
        bgn = 1'b1;
        tick();
        bgn = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_data", 32'(data_outbus), 32'h0000);
        chk("abort_key", 32'(key_outbus), 32'h0000);
        chk("abort_fin", 32'(fin), 32'd0);
        nfin = 0;
        repeat (25) begin
            tick();
            if (fin) nfin++;
        end
        chk("abort_nofin", 32'(nfin), 32'd0);
        p  = 16'($urandom);
        kk = 16'($urandom);
        run_op(2'b01, p, kk, 1'b0, 1'b0, d, k);
        m_enc(p, kk, 4, ed, ek);
        chk("after_abort_data", 32'(d), 32'(ed));

        p  = 16'($urandom);
        kk = 16'($urandom);
        cript_or_decript_signal = 2'b01;
        data_inbus = p;
        key_inbus  = kk;
        bgn = 1'b1;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (fin) q.push_back(e);
        end
        bgn = 1'b0;
        chk("held_count", 32'(q.size()), 32'd2);
        if (q.size() >= 1) chk("held_first", 32'(q[0]), 32'd18);
        if (q.size() >= 2) chk("held_gap", 32'(q[1] - q[0]), 32'd19);
        m_enc(p, kk, 4, ed, ek);
        chk("held_data", 32'(data_outbus), 32'(ed));
        repeat (25) tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
